wb_buttons: RTL and testbench

WB_BUTTONS -- requirements
Module: wb_buttons

---
 rtl/wb_buttons.sv | 144 ++++++++++++++
 tb/tb_wb_buttons.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_buttons.sv
// wb_buttons -- five-button debouncer with a Wishbone register block.
//
// Each raw pad is synchronized (2 flops), then debounced by a per-button
// counter: a level change is accepted only after the synced value has
// differed from the accepted level for db_cycles consecutive clocks.
// Presses (accepted 0->1) latch a pending bit; intr = |(pend & mask).
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   btn[4:0]          raw pads: [0]=mode [1]=up [2]=down [3]=left [4]=right
//   wb_*              Wishbone slave, one wait state, regs on wb_adr_i[3:2]
//                       0 STATE (RO) 1 PEND (W1C) 2 MASK (RW) 3 reads 0
//   intr              interrupt request
//   btn_clean[4:0]    debounced levels

// Per-button synchronizer + debounce FSM.
module wb_buttons_lane #(
  parameter int db_cycles = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic d,
  output logic rise
);
  localparam logic ST_STABLE   = 1'b0;
  localparam logic ST_CHANGING = 1'b1;
  localparam logic [19:0] CNT_MAX = 20'(db_cycles - 1);

  logic [1:0]  sync;
  logic [19:0] cnt;
  logic        state;
  logic        diff;

  assign diff = sync[1] ^ d;
  // Accepted 0->1 transition happens on the edge where d is loaded with 1.
  assign rise = (state == ST_CHANGING) && diff && (cnt == CNT_MAX) && sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      state <= ST_STABLE;
      d     <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      case (state)
        ST_STABLE: begin
          if (diff) begin
            state <= ST_CHANGING;
            cnt   <= 20'd1;
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          if (!diff) begin
            // glitch: back to the accepted level before the count completed
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            d     <= sync[1];
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
      endcase
    end
  end
endmodule

module wb_buttons #(
  parameter int db_cycles = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        intr,
  output logic [4:0]  btn_clean
);
  localparam int NUM_LANES = 5;

  logic [NUM_LANES-1:0] d, rise, pend, mask, pend_clr;
  logic [31:0]          rd_data;
  logic                 req, wr;
  logic [1:0]           reg_sel;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    wb_buttons_lane #(.db_cycles(db_cycles)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn[i]),
      .d       (d[i]),
      .rise    (rise[i])
    );
  end

  assign btn_clean = d;
  assign intr      = |(pend & mask);

  assign reg_sel = wb_adr_i[3:2];
  assign req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  // Writes land on the edge that closes the ack cycle.
  assign wr      = wb_ack_o & wb_stb_i & wb_cyc_i & wb_we_i & wb_sel_i[0];
  assign pend_clr = (wr && reg_sel == 2'd1) ? wb_dat_i[4:0] : '0;

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      2'd0:    rd_data[4:0] = d;
      2'd1:    rd_data[4:0] = pend;
      2'd2:    rd_data[4:0] = mask;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      pend     <= '0;
      mask     <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rd_data : '0;
      // a press in the same cycle as its W1C clear wins
      pend     <= (pend & ~pend_clr) | rise;
      if (wr && reg_sel == 2'd2) mask <= wb_dat_i[4:0];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:5], wb_sel_i[3:1]};
endmodule

// File: tb/tb_wb_buttons.sv
module tb_wb_buttons;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btn;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o, intr;
  logic [4:0]  btn_clean;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        ack_prev = 1'b0;

  wb_buttons #(.db_cycles(4)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .intr(intr), .btn_clean(btn_clean)
  );

  always #5 clk = ~clk;

  // Scoreboard: read acks pop the expected data queued when the read was issued.
  always @(negedge clk) begin
    if (wb_ack_o && !wb_we_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected_ack got %h", wb_dat_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (wb_dat_o !== e) begin
          errors++;
          $display("FAIL rd_data got %h exp %h", wb_dat_o, e);
        end
      end
    end
    if (wb_ack_o && ack_prev) begin
      checks++;
      errors++;
      $display("FAIL ack_width got 1 for two cycles exp single-cycle");
    end
    ack_prev = wb_ack_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
  endtask

  // Issues one access held through its ack cycle; bounded wait for ack.
  task automatic wb_access(input logic we, input logic [1:0] a,
                           input logic [31:0] dat, input logic [3:0] sel);
    int k;
    wb_adr_i = {28'h0, a, 2'b00}; wb_dat_i = dat; wb_sel_i = sel;
    wb_we_i = we; wb_stb_i = 1; wb_cyc_i = 1;
    k = 0;
    tick();
    while (!wb_ack_o && k < 8) begin tick(); k++; end
    checks++;
    if (!wb_ack_o) begin
      errors++;
      $display("FAIL ack_timeout got 0 exp 1 adr %0d", a);
    end
    tick();
    bus_idle();
  endtask

  task automatic wb_read(input logic [1:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    wb_access(1'b0, a, 32'h0, 4'hF);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] dat);
    wb_access(1'b1, a, dat, 4'h1);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 0; btn = '0; bus_idle();
    tick(); tick();
    checks++;
    if (btn_clean !== 5'b0 || intr !== 1'b0 || wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got clean %b intr %b ack %b dat %h exp all 0",
               btn_clean, intr, wb_ack_o, wb_dat_o);
    end
    rst = 1;
    tick();
    wb_read(2'd0, 32'h0);
    wb_read(2'd1, 32'h0);
    wb_read(2'd2, 32'h0);
  endtask

  task automatic test_debounce();
    btn[1] = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_bit($sformatf("debounce_d1_c%0d", k), btn_clean[1], k == 6);
    end
    wb_read(2'd1, 32'h02);
    check_bit("debounce_intr_masked", intr, 1'b0);
    wb_read(2'd0, 32'h02);
    wb_write(2'd1, 32'h1F);
    btn[1] = 0;
    repeat (8) tick();
    check_bit("release_d1", btn_clean[1], 1'b0);
    wb_read(2'd1, 32'h00);
  endtask

  task automatic test_mask_intr();
    wb_write(2'd2, 32'h1F);
    wb_read(2'd2, 32'h1F);
    btn[3] = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_bit($sformatf("intr_c%0d", k), intr, k == 6);
    end
    wb_read(2'd0, 32'h08);
    wb_adr_i = 32'h4; wb_dat_i = 32'h08; wb_sel_i = 4'h1;
    wb_we_i = 1; wb_stb_i = 1; wb_cyc_i = 1;
    tick();
    check_bit("w1c_ack", wb_ack_o, 1'b1);
    check_bit("intr_in_ack", intr, 1'b1);
    tick();
    bus_idle();
    check_bit("intr_after_w1c", intr, 1'b0);
    btn[3] = 0;
    repeat (8) tick();
    wb_read(2'd0, 32'h00);
    check_bit("intr_after_release", intr, 1'b0);
  endtask

  task automatic test_glitch();
    btn[0] = 1; tick(); tick(); btn[0] = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_bit("glitch2_d0", btn_clean[0], 1'b0);
    end
    btn[0] = 1; tick(); tick(); tick(); btn[0] = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_bit("glitch3_d0", btn_clean[0], 1'b0);
    end
    wb_read(2'd1, 32'h00);
    check_bit("glitch_intr", intr, 1'b0);
  endtask

  task automatic test_w1c_collide();
    btn[2] = 1;
    repeat (4) tick();
    // ack on edge 5, write lands on edge 6 together with the press
    wb_adr_i = 32'h4; wb_dat_i = 32'h04; wb_sel_i = 4'h1;
    wb_we_i = 1; wb_stb_i = 1; wb_cyc_i = 1;
    tick();
    check_bit("collide_d2_before", btn_clean[2], 1'b0);
    tick();
    bus_idle();
    check_bit("collide_d2_after", btn_clean[2], 1'b1);
    check_bit("collide_intr", intr, 1'b1);
    wb_read(2'd1, 32'h04);
    wb_write(2'd1, 32'h04);
    btn[2] = 0;
    repeat (8) tick();
    wb_read(2'd1, 32'h00);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; exp_rd[2] = 32'h1F; exp_rd[3] = 32'h0;
    wb_we_i = 0; wb_sel_i = 4'hF; wb_stb_i = 1; wb_cyc_i = 1;
    for (int a = 0; a < 4; a++) begin
      wb_adr_i = 32'(a) << 2;
      exp_q.push_back(exp_rd[a]);
      tick();
      check_bit($sformatf("b2b_ack_hi_%0d", a), wb_ack_o, 1'b1);
      tick();
      check_bit($sformatf("b2b_ack_lo_%0d", a), wb_ack_o, 1'b0);
    end
    bus_idle();
    wb_access(1'b1, 2'd2, 32'h0, 4'b0010);
    wb_read(2'd2, 32'h1F);
    wb_write(2'd0, 32'h1F);
    wb_write(2'd3, 32'h1F);
    wb_read(2'd0, 32'h00);
    wb_read(2'd3, 32'h00);
    // cyc low / stb low: no ack, no write
    wb_adr_i = 32'h8; wb_dat_i = 32'h0; wb_sel_i = 4'hF; wb_we_i = 1;
    wb_stb_i = 1; wb_cyc_i = 0;
    repeat (3) begin tick(); check_bit("nocyc_ack", wb_ack_o, 1'b0); end
    wb_stb_i = 0; wb_cyc_i = 1;
    repeat (3) begin tick(); check_bit("nostb_ack", wb_ack_o, 1'b0); end
    bus_idle();
    wb_read(2'd2, 32'h1F);
  endtask

  task automatic test_reset_mid();
    btn[4] = 1;
    repeat (4) tick();
    wb_adr_i = 32'h0; wb_we_i = 0; wb_sel_i = 4'hF; wb_stb_i = 1; wb_cyc_i = 1;
    rst = 0;
    #1;
    checks++;
    if (btn_clean !== 5'b0 || intr !== 1'b0 || wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs got clean %b intr %b ack %b dat %h exp all 0",
               btn_clean, intr, wb_ack_o, wb_dat_o);
    end
    repeat (2) begin tick(); check_bit("midreset_ack", wb_ack_o, 1'b0); end
    bus_idle();
    rst = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_bit($sformatf("redebounce_d4_c%0d", k), btn_clean[4], k == 6);
    end
    wb_read(2'd1, 32'h10);
    check_bit("midreset_intr_masked", intr, 1'b0);
    wb_write(2'd2, 32'h10);
    check_bit("midreset_intr_unmasked", intr, 1'b1);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_mask_intr();
    test_glitch();
    test_w1c_collide();
    test_back_to_back();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
